// File: rtl/rvfi_mem_pkg.sv
// rvfi_mem_pkg: entry type, width helpers and default parameters for rvfi_mem_model.
// The err field exists only when RVFI_MEM_ERR_EN is defined.
package rvfi_mem_pkg;
    localparam int LAT_DEF      = 1;
    localparam int DEPTH_DEF    = 4;
    localparam int MAXSTALL_DEF = 3;
    localparam int AGE_W        = 8;

    typedef struct packed {
        logic             we;
`ifdef RVFI_MEM_ERR_EN
        logic             err;
`endif
        logic [AGE_W-1:0] age;
    } mem_entry_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int stall_w(input int maxstall);
        return $clog2(maxstall + 1);
    endfunction
endpackage

// File: rtl/rvfi_mem_chan.sv
// rvfi_mem_chan: one channel's in-order response FIFO, latency ages and grant-stall limiter.
// RVFI_MEM_ERR_EN enables per-entry error storage.
module rvfi_mem_chan import rvfi_mem_pkg::*; #(
    parameter int DW       = 32,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LAT      = LAT_DEF,
    parameter int MAXSTALL = MAXSTALL_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req,
    input  logic                      we,
    input  logic                      err_req,
    input  logic                      rand_gnt,
    input  logic [DW-1:0]             rand_rdata,
    output logic                      gnt,
    output logic                      rvalid,
    output logic                      err,
    output logic [DW-1:0]             rdata,
    output logic [cnt_w(DEPTH)-1:0]   cnt
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int SW = stall_w(MAXSTALL);
    localparam logic [AGE_W-1:0] LAT_A   = AGE_W'(LAT);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0]    MS_C    = SW'(MAXSTALL);

    mem_entry_t    q [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [SW-1:0] stall;
    logic          room;

    always_comb begin
        rvalid = cnt != '0 && q[rp].age >= LAT_A;
        room   = cnt < DEPTH_C || rvalid;
        gnt    = rst_ni && req && room && (rand_gnt || stall == MS_C);
`ifdef RVFI_MEM_ERR_EN
        err    = rvalid && q[rp].err;
`else
        err    = 1'b0;
`endif
        rdata  = (rvalid && !q[rp].we && !err) ? rand_rdata : '0;
    end

`ifndef RVFI_MEM_ERR_EN
    logic unused_err;
    assign unused_err = err_req;
`endif

    // age counts the accept cycle itself, so LAT=1 answers in the cycle after the grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            stall <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (q[i].age < LAT_A) q[i].age <= q[i].age + 1'b1;
            if (gnt) begin
                q[wp].we  <= we;
`ifdef RVFI_MEM_ERR_EN
                q[wp].err <= err_req;
`endif
                q[wp].age <= AGE_W'(1);
                wp        <= wp + 1'b1;
            end
            if (rvalid) rp <= rp + 1'b1;
            cnt   <= cnt + CW'(gnt) - CW'(rvalid);
            stall <= (!req || gnt) ? '0 : (room && stall != MS_C) ? stall + 1'b1 : stall;
        end
    end
endmodule

// File: rtl/rvfi_mem_model.sv
// rvfi_mem_model: multi-channel stalling memory responder driven by free inputs.
// RVFI_MEM_ERR_EN enables error responses (rand_err_i or misaligned full-word access).
module rvfi_mem_model import rvfi_mem_pkg::*; #(
    parameter int NCH      = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LAT      = LAT_DEF,
    parameter int MAXSTALL = MAXSTALL_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NCH-1:0]                      req_i,
    input  logic [NCH-1:0]                      we_i,
    input  logic [NCH-1:0][AW-1:0]              addr_i,
    input  logic [NCH-1:0][DW-1:0]              wdata_i,
    input  logic [NCH-1:0][DW/8-1:0]            be_i,
    input  logic [NCH-1:0]                      rand_gnt_i,
    input  logic [NCH-1:0][DW-1:0]              rand_rdata_i,
    input  logic [NCH-1:0]                      rand_err_i,
    output logic [NCH-1:0]                      gnt_o,
    output logic [NCH-1:0]                      rvalid_o,
    output logic [NCH-1:0][DW-1:0]              rdata_o,
    output logic [NCH-1:0]                      err_o,
    output logic [NCH-1:0][cnt_w(DEPTH)-1:0]    cnt_o
);
    localparam int BW = $clog2(DW/8);

    logic unused_in;
    assign unused_in = ^{wdata_i, addr_i, be_i, rand_err_i};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic err_req;
`ifdef RVFI_MEM_ERR_EN
        assign err_req = rand_err_i[i] | (&be_i[i] && addr_i[i][BW-1:0] != '0);
`else
        assign err_req = 1'b0;
`endif
        rvfi_mem_chan #(.DW(DW), .DEPTH(DEPTH), .LAT(LAT), .MAXSTALL(MAXSTALL)) u_chan (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .req        (req_i[i]),
            .we         (we_i[i]),
            .err_req    (err_req),
            .rand_gnt   (rand_gnt_i[i]),
            .rand_rdata (rand_rdata_i[i]),
            .gnt        (gnt_o[i]),
            .rvalid     (rvalid_o[i]),
            .err        (err_o[i]),
            .rdata      (rdata_o[i]),
            .cnt        (cnt_o[i])
        );
    end
endmodule

// File: tb/tb_rvfi_mem_model.sv
// tb_rvfi_mem_model: three configurations of rvfi_mem_model checked against a cycle-stamped queue model.
// RVFI_MEM_ERR_EN switches the expected error behaviour.
module tb_rvfi_mem_model;
    typedef struct { bit we; bit err; int a; } ent_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [1:0]       req, we, rgnt, rerr;
    logic [1:0][31:0] addr, wdata, rdin;
    logic [1:0][3:0]  be;
    logic [1:0]       gnt [3];
    logic [1:0]       rv [3];
    logic [1:0]       er [3];
    logic [1:0][31:0] rd [3];
    logic [1:0][2:0]  cnt0, cnt1;
    logic [1:0][1:0]  cnt2;

    ent_t mq [3][2][$];
    int   st [3][2];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rvfi_mem_model #(.NCH(2), .AW(32), .DW(32), .DEPTH(4), .LAT(1), .MAXSTALL(3)) d0 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .be_i(be), .rand_gnt_i(rgnt), .rand_rdata_i(rdin), .rand_err_i(rerr),
        .gnt_o(gnt[0]), .rvalid_o(rv[0]), .rdata_o(rd[0]), .err_o(er[0]), .cnt_o(cnt0));
    rvfi_mem_model #(.NCH(2), .AW(32), .DW(32), .DEPTH(4), .LAT(3), .MAXSTALL(3)) d1 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .be_i(be), .rand_gnt_i(rgnt), .rand_rdata_i(rdin), .rand_err_i(rerr),
        .gnt_o(gnt[1]), .rvalid_o(rv[1]), .rdata_o(rd[1]), .err_o(er[1]), .cnt_o(cnt1));
    rvfi_mem_model #(.NCH(2), .AW(32), .DW(32), .DEPTH(2), .LAT(4), .MAXSTALL(1)) d2 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .be_i(be), .rand_gnt_i(rgnt), .rand_rdata_i(rdin), .rand_err_i(rerr),
        .gnt_o(gnt[2]), .rvalid_o(rv[2]), .rdata_o(rd[2]), .err_o(er[2]), .cnt_o(cnt2));

    function automatic int lat_of(input int d);
        return d == 0 ? 1 : d == 1 ? 3 : 4;
    endfunction

    function automatic int depth_of(input int d);
        return d == 2 ? 2 : 4;
    endfunction

    function automatic int ms_of(input int d);
        return d == 2 ? 1 : 3;
    endfunction

    function automatic int get_cnt(input int d, input int c);
        return d == 0 ? int'(cnt0[c]) : d == 1 ? int'(cnt1[c]) : int'(cnt2[c]);
    endfunction

    function automatic bit err_of(input int c);
`ifdef RVFI_MEM_ERR_EN
        return rerr[c] || (be[c] == 4'hF && addr[c][1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // a request granted in cycle a may answer from cycle a+LAT on
    function automatic bit ready(input int d, input int c);
        return mq[d][c].size() > 0 && cyc - mq[d][c][0].a >= lat_of(d);
    endfunction

    function automatic bit gnt_exp(input int d, input int c);
        return req[c] && (mq[d][c].size() < depth_of(d) || ready(d, c)) &&
               (rgnt[c] || st[d][c] == ms_of(d));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 2; c++) begin
                bit   on  = rst_ni;
                bit   rdy = on && ready(d, c);
                ent_t h   = '{0, 0, 0};
                if (rdy) h = mq[d][c][0];
                check($sformatf("d%0d.c%0d.gnt", d, c), 64'(gnt[d][c]), 64'(on && gnt_exp(d, c)));
                check($sformatf("d%0d.c%0d.rvalid", d, c), 64'(rv[d][c]), 64'(rdy));
                check($sformatf("d%0d.c%0d.rdata", d, c), 64'(rd[d][c]),
                      64'((rdy && !h.we && !h.err) ? rdin[c] : 32'h0));
                check($sformatf("d%0d.c%0d.err", d, c), 64'(er[d][c]), 64'(rdy && h.err));
                check($sformatf("d%0d.c%0d.cnt", d, c), 64'(get_cnt(d, c)),
                      64'(on ? mq[d][c].size() : 0));
            end
    endtask

    task automatic update();
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 2; c++) begin
                if (!rst_ni) begin
                    mq[d][c].delete();
                    st[d][c] = 0;
                end else begin
                    bit rdy  = ready(d, c);
                    bit g    = gnt_exp(d, c);
                    bit room = mq[d][c].size() < depth_of(d) || rdy;
                    if (rdy) void'(mq[d][c].pop_front());
                    if (g) mq[d][c].push_back('{we[c], err_of(c), cyc});
                    if (!req[c] || g) st[d][c] = 0;
                    else if (room && st[d][c] < ms_of(d)) st[d][c]++;
                end
            end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic idle();
        req = '0; we = '0; rgnt = '0; rerr = '0;
        addr = '0; wdata = '0; be = '0; rdin = '0;
    endtask

    task automatic rand_inputs();
        for (int c = 0; c < 2; c++) begin
            req[c]   = $urandom_range(0, 9) < 7;
            we[c]    = 1'($urandom_range(0, 1));
            addr[c]  = $urandom;
            wdata[c] = $urandom;
            be[c]    = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
            rgnt[c]  = $urandom_range(0, 1) == 1;
            rdin[c]  = $urandom;
            rerr[c]  = $urandom_range(0, 9) == 0;
        end
    endtask

    initial begin
        idle();
        repeat (2) step();
        rst_ni = 1'b1;
        // single read with LAT=1 answering the next cycle
        req[0] = 1'b1; addr[0] = 32'h100; be[0] = 4'hF; rgnt = 2'b11; rdin[0] = 32'hDEADBEEF;
        step();
        req[0] = 1'b0;
        repeat (4) step();
        // back-to-back accepts
        req[0] = 1'b1; we[0] = 1'b1;
        repeat (6) begin rdin[0] = $urandom; step(); end
        idle();
        repeat (6) step();
        // grant starvation bound
        req[1] = 1'b1;
        repeat (6) step();
        idle();
        repeat (2) step();
        // channel 0 filled on the shallow instance while channel 1 requests
        req[0] = 1'b1; rgnt = 2'b11;
        repeat (4) step();
        req[1] = 1'b1;
        repeat (4) step();
        idle();
        repeat (6) step();
        // misaligned full-word read
        req[1] = 1'b1; addr[1] = 32'h102; be[1] = 4'hF; rgnt = 2'b11; rdin[1] = 32'h12345678;
        step();
        req[1] = 1'b0;
        repeat (6) step();
        repeat (2000) begin rand_inputs(); step(); end
        // asynchronous reset with requests in flight
        idle();
        req = 2'b11; rgnt = 2'b11;
        repeat (2) step();
        rst_ni = 1'b0;
        #1;
        check_all();
        step();
        rst_ni = 1'b1;
        idle();
        repeat (6) step();
        repeat (500) begin rand_inputs(); step(); end
        idle();
        repeat (6) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
